// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one 16-bit logical-left barrel shifter
// among NUM_REQ valid/ready requesters. Results go through one registered slot,
// tagged with the requester index, and honour downstream backpressure.
module shift_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_op,
  input  logic [4*NUM_REQ-1:0]    req_mag,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    res_valid,
  output logic [15:0]             res_data,
  output logic [ID_W-1:0]         res_id,
  input  logic                    res_ready
);

  logic              res_valid_q, res_valid_d;
  logic [15:0]       res_data_q,  res_data_d;
  logic [ID_W-1:0]   res_id_q,    res_id_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;

  logic              accept;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   search_idx;
  logic [15:0]       op_arr  [NUM_REQ];
  logic [3:0]        mag_arr [NUM_REQ];
  logic [15:0]       grant_op;
  logic [3:0]        grant_mag;

  // Split the flat operand/magnitude buses into per-requester lanes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_arr[i]  = req_op[16*i +: 16];
      mag_arr[i] = req_mag[4*i +: 4];
    end
  end

  // Round-robin search from rr_ptr; at most one one-hot grant, none in reset.
  always_comb begin
    accept      = !res_valid_q || res_ready;
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    req_ready   = '0;
    if (rst_n && accept) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        search_idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!grant_found && req_valid[search_idx]) begin
          grant_found = 1'b1;
          grant_idx   = search_idx;
        end
      end
    end
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Shifter datapath and next state of the result slot and pointer.
  always_comb begin
    grant_op    = op_arr[grant_idx];
    grant_mag   = mag_arr[grant_idx];
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_found) begin
      res_valid_d = 1'b1;
      res_data_d  = grant_op << grant_mag;
      res_id_d    = grant_idx;
      rr_ptr_d    = ID_W'((32'(grant_idx) + 1) % NUM_REQ);
    end else if (res_ready) begin
      // drain without refill: data/id keep their last values
      res_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed table plus multi-cycle sequences for shift_arbiter,
// with a cycle-level reference model and result scoreboard running alongside.
module tb_shift_arbiter;

  localparam int unsigned N = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      rv;
  logic [15:0]       op  [N];
  logic [3:0]        mag [N];
  logic [16*N-1:0]   req_op;
  logic [4*N-1:0]    req_mag;
  logic [N-1:0]      req_ready;
  logic              res_valid;
  logic [15:0]       res_data;
  logic [1:0]        res_id;
  logic              res_ready;

  int total = 0;
  int bad   = 0;

  assign req_op  = {op[3], op[2], op[1], op[0]};
  assign req_mag = {mag[3], mag[2], mag[1], mag[0]};

  shift_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_op    (req_op),
    .req_mag   (req_mag),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard (sampled on negedge) -------
  logic [17:0]  sb[$];
  logic         m_valid;
  logic [15:0]  m_data;
  logic [1:0]   m_id;
  logic [1:0]   m_rr;
  logic         pend;
  logic [17:0]  popped;
  logic [N-1:0] exp_ready;
  int           g;
  int           idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_id = '0; m_rr = '0; pend = 1'b0;
      sb.delete();
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_data",  32'(res_data),  32'd0);
      check("rst_id",    32'(res_id),    32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
    end else begin
      if (pend) begin
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
          popped = sb.pop_front();
          m_data = popped[17:2];
          m_id   = popped[1:0];
        end
      end
      check("mon_valid", 32'(res_valid), 32'(m_valid));
      check("mon_data",  32'(res_data),  32'(m_data));
      check("mon_id",    32'(res_id),    32'(m_id));
      g = -1;
      if (!m_valid || res_ready) begin
        for (int k = 0; k < 4; k++) begin
          idx = (int'(m_rr) + k) % 4;
          if (g < 0 && rv[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("mon_ready", 32'(req_ready), 32'(exp_ready));
      if (g >= 0) begin
        sb.push_back({16'(op[g] << mag[g]), 2'(g)});
        pend    = 1'b1;
        m_valid = 1'b1;
        m_rr    = 2'((g + 1) % 4);
      end else begin
        pend = 1'b0;
        if (res_ready) m_valid = 1'b0;
      end
    end
  end

  // ---------------- directed vectors ----------------------------------------
  typedef struct {
    int          who;
    logic [15:0] op;
    logic [3:0]  mag;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_grant(input int who);
    int n = 0;
    @(negedge clk);
    while (!req_ready[who] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait", 32'(req_ready[who]), 32'd1);
  endtask

  logic [15:0] rr_exp [4];

  initial begin
    vecs[0] = '{2, 16'hA5C3, 4'd4,  16'h5C30};
    vecs[1] = '{0, 16'h8001, 4'd0,  16'h8001};
    vecs[2] = '{1, 16'h8001, 4'd15, 16'h8000};
    vecs[3] = '{1, 16'h1234, 4'd8,  16'h3400};
    vecs[4] = '{3, 16'h0001, 4'd15, 16'h8000};
    rr_exp[0] = 16'h2468; rr_exp[1] = 16'hAF34;
    rr_exp[2] = 16'h7878; rr_exp[3] = 16'h4210;

    rst_n = 1'b0; res_ready = 1'b1; rv = '0;
    for (int i = 0; i < 4; i++) begin op[i] = '0; mag[i] = '0; end
    rv = 4'hF;
    repeat (2) @(negedge clk);
    check("reset_ready_gated", 32'(req_ready), 32'd0);
    rv = '0;
    @(posedge clk); #3 rst_n = 1'b1;

    // single requester, one vector per row
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      rv = '0;
      rv[vecs[v].who]  = 1'b1;
      op[vecs[v].who]  = vecs[v].op;
      mag[vecs[v].who] = vecs[v].mag;
      wait_grant(vecs[v].who);
      @(posedge clk); #1 rv = '0;
      @(negedge clk);
      check("vec_valid", 32'(res_valid), 32'd1);
      check("vec_data",  32'(res_data),  32'(vecs[v].exp_data));
      check("vec_id",    32'(res_id),    32'(vecs[v].who));
    end

    // all requesters continuously valid: strict rotation, no bubbles
    @(posedge clk); #1;
    op[0] = 16'h1234; mag[0] = 4'd1;
    op[1] = 16'hABCD; mag[1] = 4'd2;
    op[2] = 16'h0F0F; mag[2] = 4'd3;
    op[3] = 16'h8421; mag[3] = 4'd4;
    rv = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rr_valid", 32'(res_valid), 32'd1);
      check("rr_id",    32'(res_id),    32'(k % 4));
      check("rr_data",  32'(res_data),  32'(rr_exp[k % 4]));
    end

    // backpressure: slot holds id 1 / 0F00 while req 3 waits
    @(posedge clk); #1;
    rv = 4'b0010; op[1] = 16'h00F0; mag[1] = 4'd4;
    @(negedge clk);
    check("bp_fill_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    rv = 4'b1000; op[3] = 16'h1234; mag[3] = 4'd0; res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_id",    32'(res_id),    32'd1);
      check("bp_data",  32'(res_data),  32'h0F00);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'b1000);
    @(posedge clk); #1 rv = '0;
    @(negedge clk);
    check("bp_next_id",   32'(res_id),   32'd3);
    check("bp_next_data", 32'(res_data), 32'h1234);

    // pointer skip: move pointer to 1, then only reqs 0 and 3
    @(posedge clk); #1 rv = 4'b0001;
    wait_grant(0);
    @(posedge clk); #1 rv = 4'b1001;
    @(negedge clk);
    check("skip_grant3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1 rv = 4'b0001;
    @(negedge clk);
    check("skip_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 rv = '0;
    @(negedge clk);
    check("skip_last_valid", 32'(res_valid), 32'd1);
    check("skip_last_id",    32'(res_id),    32'd0);
    @(negedge clk);
    check("idle_drain", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("idle_hold", 32'(res_valid), 32'd0);
    check("idle_keep_id", 32'(res_id), 32'd0);
    @(posedge clk); #1 rv = 4'hF;
    @(negedge clk);
    check("ptr_held_at_1", 32'(req_ready), 32'b0010);

    // asynchronous reset mid-stream
    @(negedge clk);
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_data",  32'(res_data),  32'd0);
    check("async_rst_id",    32'(res_id),    32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 rv = '0;
    @(negedge clk);
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_id",    32'(res_id),    32'd0);
    check("post_rst_data",  32'(res_data),  32'h2468);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one 16-bit logical-left barrel shifter among NUM_REQ requesters with a round-robin arbiter. The shifter datapath is an internal `op << shift_mag` with zero fill. Each requester uses a valid/ready handshake. Results go through a single registered output slot, tagged with the requester index, and honour downstream backpressure.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  NUM_REQ  bit i: requester i presents an operation.
req_op  input  16*NUM_REQ  operand of requester i in bits [16*i+15:16*i].
req_mag  input  4*NUM_REQ  shift magnitude of requester i in bits [4*i+3:4*i], range 0..15.
req_ready  output  NUM_REQ  bit i: requester i's operation is accepted this cycle.
res_valid  output  1  result slot holds a valid result.
res_data  output  16  shifted result.
res_id  output  ID_W  index of the requester that produced res_data.
res_ready  input  1  downstream consumes the result when res_valid && res_ready.

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous and active-low; when rst_n=0:
  - res_valid=0, res_data=0, res_id=0;
  - round-robin pointer rr_ptr=0;
  - req_ready=0 while in reset.
- Accept condition: accept = !res_valid || res_ready, combinational. A full slot that is drained this cycle may be refilled in the same cycle.
- Grant:
  - When accept=1, grant the lowest index i, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, … mod NUM_REQ), with req_valid[i]=1.
  - req_ready is one-hot on the granted bit and all zeros otherwise. It is combinational from req_valid, rr_ptr, res_valid and res_ready.
- Rules on requesters:
  - A requester holds req_valid, req_op and req_mag stable until it sees req_ready.
  - The arbiter never drops a transfer and never grants more than one requester per cycle.
- On a grant to i, at the next edge:
  - res_data = (req_op_i << req_mag_i) truncated to 16 bits; vacated LSBs are 0;
  - res_id = i; res_valid = 1;
  - rr_ptr = (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the accept edge to res_valid.
  - Sustained throughput is 1 result per cycle when res_ready is held at 1.
- Drain with no new grant (res_valid && res_ready and no granted request): res_valid = 0 at the next edge. res_data and res_id keep their last values.
- Backpressure (res_valid=1, res_ready=0):
  - req_ready = 0; rr_ptr holds; res_valid, res_data and res_id stay stable.
- Idle (no req_valid): rr_ptr holds. The pointer advances only on a grant.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,…,NUM_REQ-1,0. Any continuously-valid requester waits at most NUM_REQ-1 grants.
- Magnitude edge cases: mag=0 gives res_data=op. mag=15 gives res_data={op[0],15'b0}.
- Reset mid-operation: an in-flight result is discarded without handshake. The next grant after reset is searched from index 0.

Test Plan:
- Single requester, directed values, res_ready=1, others idle:
  - req 2, op=16'hA5C3, mag=4 -> req_ready[2]=1 for one cycle; next cycle res_valid=1, res_data=16'h5C30, res_id=2.
  - op=16'h8001, mag=0 -> res_data=16'h8001; mag=15 -> res_data=16'h8000.
- All 4 requesters continuously valid with distinct ops, res_ready=1, 12 cycles -> res_id sequence 0,1,2,3,0,1,2,3,0,1,2,3; each res_data equals that requester's op<<mag; no idle cycles.
- Backpressure: fill the slot (res_id=1, res_data=16'h0F00), hold res_ready=0 for 5 cycles with req 3 valid -> req_ready=0 throughout, outputs stable. Raise res_ready -> same cycle req_ready[3]=1; next cycle res_id=3.
- Pointer skip:
  - rr_ptr=1, only reqs 0 and 3 valid -> grant 3, then 0; rr_ptr ends at 1.
  - After that, no requests for 3 cycles -> rr_ptr stays 1, res_valid drops to 0 after one drain.
- Reset mid-stream: assert rst_n=0 asynchronously (between edges) while res_valid=1 -> res_valid, res_data and res_id go to 0 immediately. After release with all reqs valid -> first grant goes to req 0.
